// File: rtl/uart_tx_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_driver: IO-mapped 8N1 UART transmitter with byte FIFO and status |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_tx_driver #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        iUartTxCtrl,
    input  logic        iIoWrite,
    input  logic        iIoRead,
    input  logic [7:0]  iWriteData,
    output logic [15:0] oStatus,
    output logic        oUartToPc,
    output logic        oTxDone
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W        = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [BAUD_W-1:0]  baud_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic               line_q;
    logic               done_q;

    logic               wr_q;
    logic               rd_q;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               ovf_q;

    logic wr_req, rd_req, push, rd_edge, full, empty, pop, push_ok, last_tick;

    assign wr_req    = iUartTxCtrl & iIoWrite;
    assign rd_req    = iUartTxCtrl & iIoRead;
    assign push      = wr_req & ~wr_q;
    assign rd_edge   = rd_req & ~rd_q;
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign pop       = (state_q == IDLE) & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    assign push_ok   = push & (~full | pop);
    assign last_tick = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wptr_q] <= iWriteData;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_req;
            rd_q    <= rd_req;
            count_q <= count_d;
            if (push_ok) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (push && !push_ok) begin
                ovf_q <= 1'b1;
            end else if (rd_edge) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    line_q <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rptr_q];
                        line_q  <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (last_tick) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        line_q  <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            line_q  <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q  <= bit_q + 3'd1;
                            line_q <= shift_q[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    line_q <= 1'b1;
                    if (last_tick) begin
                        baud_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    line_q  <= 1'b1;
                    baud_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oUartToPc = line_q;
    assign oTxDone   = done_q;
    assign oStatus   = {3'b000, 9'(count_q), ovf_q, empty, full, (state_q != IDLE)};

endmodule
`default_nettype wire
